// File: rtl/an_vector_encoder.sv
// AN-code vector encoder: cw = A * msg, one lane per clock, valid/ready on both sides.
// Define AN_SELFCHECK_EN to add a residue re-check of each written codeword (+1 cycle latency).
module an_vector_encoder #(
    parameter int LANES = 10,
    parameter int MSG_W = 24,
    parameter int CW_W  = 29,
    parameter int A     = 59
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*MSG_W-1:0] msg_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*CW_W-1:0]  cw_out,
    output logic [LANES-1:0]       ovf_out,
    output logic                   selfcheck_err
);
    localparam int PW    = MSG_W + 6;
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [5:0]       A_BITS    = 6'(A);

    typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [LANES*MSG_W-1:0] msg_reg;
    logic [LANES*CW_W-1:0]  cw_reg;
    logic [LANES-1:0]       ovf_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;

    logic [CNT_W-1:0] lane_idx;
    logic [MSG_W-1:0] lane_msg;
    logic [PW-1:0]    msg_ext;
    logic [PW-1:0]    term [6];
    logic [PW-1:0]    prod;
    logic [PW-CW_W:0] prod_top;
    logic             lane_ovf;

    // The extra self-check cycle leaves cnt_reg at LANES; clamp so the lane read stays in range.
    assign lane_idx = (cnt_reg <= LAST_LANE) ? cnt_reg : '0;
    assign lane_msg = msg_reg[int'(lane_idx)*MSG_W +: MSG_W];
    assign msg_ext  = {{(PW-MSG_W){lane_msg[MSG_W-1]}}, lane_msg};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_term
            assign term[gi] = A_BITS[gi] ? (msg_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        prod = '0;
        for (int i = 0; i < 6; i++) begin
            prod = prod + term[i];
        end
    end

    assign prod_top = prod[PW-1:CW_W-1];
    assign lane_ovf = !((&prod_top) || !(|prod_top));

`ifdef AN_SELFCHECK_EN
    localparam int NCH = CW_W / 6 + 1;
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    function automatic int pow2_mod(input int e);
        int r;
        r = 1 % A;
        for (int k = 0; k < e; k++) begin
            r = (r * 2) % A;
        end
        return r;
    endfunction

    localparam logic [15:0] SIGN_RES = 16'(pow2_mod(CW_W));

    logic [CNT_W-1:0] chk_lane_reg;
    logic             chk_valid_reg;
    logic             err_reg;
    logic [CW_W-1:0]  chk_cw;
    logic [NCH*6-1:0] chk_pad;
    logic [15:0]      fold_term [NCH];
    logic [15:0]      fold_sum;
    logic [15:0]      res_u;
    logic             residue_bad;

    assign chk_cw  = cw_reg[int'(chk_lane_reg)*CW_W +: CW_W];
    assign chk_pad = {{(NCH*6-CW_W){1'b0}}, chk_cw};

    // Fold 6-bit chunks by their weight 2^(6i) mod A, then finish with a small constant modulo.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_fold
            localparam logic [15:0] WEIGHT = 16'(pow2_mod(6 * gi));
            assign fold_term[gi] = 16'(chk_pad[6*gi +: 6]) * WEIGHT;
        end
    endgenerate

    always_comb begin
        fold_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            fold_sum = fold_sum + fold_term[i];
        end
    end

    // Signed value = u - 2^CW_W*sign, so a multiple of A needs u == sign*(2^CW_W mod A).
    assign res_u       = fold_sum % 16'(A);
    assign residue_bad = (res_u != (chk_cw[CW_W-1] ? SIGN_RES : 16'd0)) && !ovf_reg[chk_lane_reg];
    assign selfcheck_err = err_reg;
`else
    assign selfcheck_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            msg_reg       <= '0;
            cw_reg        <= '0;
            ovf_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef AN_SELFCHECK_EN
            chk_lane_reg  <= '0;
            chk_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
`endif
        end else begin
`ifdef AN_SELFCHECK_EN
            if (chk_valid_reg && residue_bad) begin
                err_reg <= 1'b1;
            end
`endif
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        msg_reg      <= msg_in;
                        ovf_reg      <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ENCODE;
`ifdef AN_SELFCHECK_EN
                        err_reg      <= 1'b0;
`endif
                    end
                end
                ENCODE: begin
`ifdef AN_SELFCHECK_EN
                    if (cnt_reg != LANES_C) begin
                        cw_reg[int'(cnt_reg)*CW_W +: CW_W] <= prod[CW_W-1:0];
                        ovf_reg[cnt_reg] <= lane_ovf;
                        chk_lane_reg     <= cnt_reg;
                        chk_valid_reg    <= 1'b1;
                        cnt_reg          <= cnt_reg + 1'b1;
                    end else begin
                        chk_valid_reg <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
`else
                    cw_reg[int'(cnt_reg)*CW_W +: CW_W] <= prod[CW_W-1:0];
                    ovf_reg[cnt_reg] <= lane_ovf;
                    cnt_reg          <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_LANE) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign cw_out    = cw_reg;
    assign ovf_out   = ovf_reg;
endmodule

// File: tb/tb_an_vector_encoder.sv
// Self-checking bench for an_vector_encoder against an integer-arithmetic reference model.
module tb_an_vector_encoder;
    localparam int LANES = 10;
    localparam int MSG_W = 24;
    localparam int CW_W  = 29;
    localparam int A     = 59;
`ifdef AN_SELFCHECK_EN
    localparam int LAT = LANES + 1;
`else
    localparam int LAT = LANES;
`endif
    localparam int PERIOD = LAT + 2;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*MSG_W-1:0] msg_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*CW_W-1:0]  cw_out;
    logic [LANES-1:0]       ovf_out;
    logic                   selfcheck_err;

    int checks   = 0;
    int failures = 0;

    an_vector_encoder #(.LANES(LANES), .MSG_W(MSG_W), .CW_W(CW_W), .A(A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .msg_in(msg_in),
        .out_valid(out_valid), .out_ready(out_ready), .cw_out(cw_out), .ovf_out(ovf_out),
        .selfcheck_err(selfcheck_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product in 64-bit integers, codeword is the product mod 2^CW_W.
    function automatic void model(input logic [LANES*MSG_W-1:0] m,
                                  output logic [LANES*CW_W-1:0] cw, output logic [LANES-1:0] ovf);
        logic signed [MSG_W-1:0] s;
        longint v, p, lim;
        lim = longint'(1) << (CW_W - 1);
        for (int i = 0; i < LANES; i++) begin
            s = m[i*MSG_W +: MSG_W];
            v = longint'(s);
            p = v * A;
            cw[i*CW_W +: CW_W] = p[CW_W-1:0];
            ovf[i] = (p >= lim) || (p < -lim);
        end
    endfunction

    function automatic logic [LANES*MSG_W-1:0] rand_vec();
        logic [LANES*MSG_W-1:0] v;
        int x;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0: x = int'($urandom);
                1: x = 4549750 + int'($urandom_range(0, 7));
                2: x = -(4549750 + int'($urandom_range(0, 7)));
                default: x = int'($urandom_range(0, 20)) - 10;
            endcase
            v[i*MSG_W +: MSG_W] = MSG_W'(x);
        end
        return v;
    endfunction

    // Presents a vector until accepted; returns with the accept edge just passed.
    task automatic send(input logic [LANES*MSG_W-1:0] v, output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        in_valid = 1'b1;
        msg_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; msg_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (cw_out !== '0 || ovf_out !== '0 || selfcheck_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: cw=%h ovf=%b err=%b required zeros", cw_out, ovf_out, selfcheck_err);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        $display("reset: done");
    endtask

    task automatic test_ones();
        logic [LANES*MSG_W-1:0] v;
        bit ok; int cyc;
        for (int i = 0; i < LANES; i++) v[i*MSG_W +: MSG_W] = MSG_W'(1);
        send(v, ok);
        wait_valid(cyc);
        checks++;
        if (!ok || cyc != LAT) begin
            failures++;
            $display("FAIL ones_latency: accepted=%0d latency=%0d required %0d", ok, cyc, LAT);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (cw_out[i*CW_W +: CW_W] !== 29'h000003B) begin
                failures++;
                $display("FAIL ones_cw lane %0d: got %h required 000003b", i, cw_out[i*CW_W +: CW_W]);
            end
        end
        checks++;
        if (ovf_out !== '0 || selfcheck_err !== 1'b0) begin
            failures++;
            $display("FAIL ones_flags: ovf=%b err=%b required 0/0", ovf_out, selfcheck_err);
        end
        take();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ones_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        $display("ones: latency=%0d", cyc);
    endtask

    task automatic test_directed();
        int dv [LANES] = '{-1, 4549753, 4549754, -4549753, -4549754, 0, 0, 0, 0, 0};
        logic [CW_W-1:0] ecw [LANES] = '{29'h1FFFFFC5, 29'h0FFFFFE3, 29'h1000001E, 29'h1000001D,
                                          29'h0FFFFFE2, 29'h0, 29'h0, 29'h0, 29'h0, 29'h0};
        logic [LANES-1:0] eovf = 10'b00000_10100;
        logic [LANES*MSG_W-1:0] v;
        bit ok; int cyc;
        for (int i = 0; i < LANES; i++) v[i*MSG_W +: MSG_W] = MSG_W'(dv[i]);
        send(v, ok);
        wait_valid(cyc);
        checks++;
        if (!ok || cyc != LAT) begin
            failures++;
            $display("FAIL dir_latency: accepted=%0d latency=%0d required %0d", ok, cyc, LAT);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (cw_out[i*CW_W +: CW_W] !== ecw[i]) begin
                failures++;
                $display("FAIL dir_cw lane %0d: got %h required %h", i, cw_out[i*CW_W +: CW_W], ecw[i]);
            end
        end
        checks++;
        if (ovf_out !== eovf) begin
            failures++;
            $display("FAIL dir_ovf: got %b required %b", ovf_out, eovf);
        end
        take();
        $display("directed: ovf=%b", ovf_out);
    endtask

    task automatic test_stall();
        logic [LANES*MSG_W-1:0] v1, v2;
        logic [LANES*CW_W-1:0] e1, e2;
        logic [LANES-1:0] o1, o2;
        bit ok; int cyc;
        v1 = rand_vec(); model(v1, e1, o1);
        v2 = rand_vec(); model(v2, e2, o2);
        send(v1, ok);
        wait_valid(cyc);
        checks++;
        if (!ok || cyc != LAT) begin
            failures++;
            $display("FAIL stall_latency: accepted=%0d latency=%0d required %0d", ok, cyc, LAT);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            msg_in = rand_vec();
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || cw_out !== e1 || ovf_out !== o1) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: out_valid=%b in_ready=%b cw=%h ovf=%b required 1/0 cw=%h ovf=%b",
                         c, out_valid, in_ready, cw_out, ovf_out, e1, o1);
            end
        end
        msg_in = v2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc != LAT || cw_out !== e2 || ovf_out !== o2) begin
            failures++;
            $display("FAIL stall_next: latency=%0d cw=%h ovf=%b required %0d cw=%h ovf=%b",
                     cyc, cw_out, ovf_out, LAT, e2, o2);
        end
        take();
        $display("stall: second vector latency=%0d", cyc);
    endtask

    task automatic test_back_to_back();
        logic [LANES*CW_W-1:0] cw_q [$];
        logic [LANES-1:0] ovf_q [$];
        logic [LANES*MSG_W-1:0] v;
        logic [LANES*CW_W-1:0] ec;
        logic [LANES-1:0] eo;
        int last_out = -1;
        int got = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got < 5; c++) begin
            if (out_valid) begin
                checks++;
                if (cw_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: output with no vector outstanding");
                end else begin
                    ec = cw_q.pop_front();
                    eo = ovf_q.pop_front();
                    if (cw_out !== ec || ovf_out !== eo) begin
                        failures++;
                        $display("FAIL b2b_data %0d: cw=%h ovf=%b required cw=%h ovf=%b", got, cw_out, ovf_out, ec, eo);
                    end
                end
                if (last_out >= 0) begin
                    checks++;
                    if (c - last_out != PERIOD) begin
                        failures++;
                        $display("FAIL b2b_period: got %0d required %0d", c - last_out, PERIOD);
                    end
                end
                $display("b2b: vector %0d out at cycle %0d", got, c);
                last_out = c;
                got++;
            end
            v = rand_vec();
            msg_in = v;
            if (in_ready) begin
                model(v, ec, eo);
                cw_q.push_back(ec);
                ovf_q.push_back(eo);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != 5 || cw_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d outputs with %0d pending, required 5 with 0", got, cw_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [LANES*MSG_W-1:0] v;
        logic [LANES*CW_W-1:0] ec;
        logic [LANES-1:0] eo;
        bit ok; int cyc;
        send(rand_vec(), ok);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cw_out !== '0 || ovf_out !== '0) begin
            failures++;
            $display("FAIL midreset_state: out_valid=%b in_ready=%b cw=%h ovf=%b required 0/1/0/0",
                     out_valid, in_ready, cw_out, ovf_out);
        end
        v = rand_vec(); model(v, ec, eo);
        send(v, ok);
        wait_valid(cyc);
        checks++;
        if (!ok || cyc != LAT || cw_out !== ec || ovf_out !== eo) begin
            failures++;
            $display("FAIL midreset_next: accepted=%0d latency=%0d cw=%h ovf=%b required %0d cw=%h ovf=%b",
                     ok, cyc, cw_out, ovf_out, LAT, ec, eo);
        end
        take();
        $display("reset_mid: recovered, latency=%0d", cyc);
    endtask

    task automatic test_random();
        logic [LANES*MSG_W-1:0] v;
        logic [LANES*CW_W-1:0] ec;
        logic [LANES-1:0] eo;
        bit ok; int cyc;
        for (int n = 0; n < 8; n++) begin
            v = rand_vec(); model(v, ec, eo);
            send(v, ok);
            wait_valid(cyc);
            checks++;
            if (!ok || cyc != LAT || cw_out !== ec || ovf_out !== eo || selfcheck_err !== 1'b0) begin
                failures++;
                $display("FAIL random %0d: latency=%0d cw=%h ovf=%b err=%b required %0d cw=%h ovf=%b err=0",
                         n, cyc, cw_out, ovf_out, selfcheck_err, LAT, ec, eo);
            end
            take();
            $display("random %0d: ovf=%b", n, ovf_out);
        end
    endtask

`ifdef AN_SELFCHECK_EN
    task automatic test_selfcheck();
        bit ok; int cyc;
        send('0, ok);
        @(posedge clk); #1;
        force dut.cw_reg = {{(LANES*CW_W-1){1'b0}}, 1'b1};
        @(posedge clk); #1;
        release dut.cw_reg;
        wait_valid(cyc);
        checks++;
        if (selfcheck_err !== 1'b1) begin
            failures++;
            $display("FAIL selfcheck_flag: got %b required 1", selfcheck_err);
        end
        take();
        checks++;
        if (selfcheck_err !== 1'b1) begin
            failures++;
            $display("FAIL selfcheck_sticky: got %b required 1", selfcheck_err);
        end
        send(rand_vec(), ok);
        wait_valid(cyc);
        checks++;
        if (selfcheck_err !== 1'b0) begin
            failures++;
            $display("FAIL selfcheck_clear: got %b required 0", selfcheck_err);
        end
        take();
        $display("selfcheck: injected flip detected");
    endtask
`endif

    initial begin
        test_reset();
        test_ones();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef AN_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
